i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
Downstream stage of the amplitude-adjust block. It serialises signed 16-bit PCM (left/right) onto the audio codec DAC data pin, with the codec as clock master (codec drives BCLK and DACLRCK). Codec pins are sampled into the `clk` domain. The block captures one stereo frame per LRCK period, shifts each channel MSB-first, and raises a per-frame tick and a framing-error pulse.

Parameters:
BITS, 16, sample width per channel (signed two's complement).
I2S_MODE, 1, 1 = Philips I2S (one-BCLK delay after LRCK edge); 0 = left-justified (MSB in the first slot).

Ports:
clk  input  1  system clock; frequency must be at least 10x BCLK.
rst_n  input  1  asynchronous active-low reset.
left_in  input  BITS  signed left sample, held continuously by the upstream stage.
right_in  input  BITS  signed right sample.
aud_bclk  input  1  codec bit clock; asynchronous to `clk`.
aud_daclrck  input  1  codec DAC word clock; 0 = left channel, 1 = right channel; asynchronous.
aud_dacdat  output  1  serial DAC data, registered.
sample_tick  output  1  one-`clk` pulse when a new stereo frame is captured.
frame_err  output  1  one-`clk` pulse when a channel slot ends before BITS bits have been sent.

Behaviour:
- Reset (asynchronous, on `rst_n` low):
  - `aud_dacdat`, `sample_tick`, `frame_err` = 0.
  - Hold registers = 0, bit counter = 0, state = WAIT_SYNC.
  - Synchroniser flops = 0.
- Synchronisation:
  - `aud_bclk` and `aud_daclrck` each pass through a 2-FF synchroniser plus one history flop.
  - `bclk_fall` = synchronised BCLK was 1 last cycle and is 0 this cycle.
  - The LRCK value is evaluated only on `bclk_fall`.
  - A boundary is a `bclk_fall` where the synchronised LRCK differs from the value latched at the previous `bclk_fall`.
- Output timing:
  - `aud_dacdat` updates on the `clk` edge following detection of `bclk_fall`, i.e. at most 4 `clk` after the physical BCLK fall.
  - It therefore settles before the codec's sampling BCLK rise.
- Frame capture:
  - At a boundary into left (LRCK becomes 0), `left_in` and `right_in` are both copied into hold registers in the same cycle.
  - `sample_tick` = 1 for that one cycle.
  - The right slot always uses the held `right_in`; input changes mid-frame have no effect until the next left boundary.
- State machine, advanced only on `bclk_fall`:
  - WAIT_SYNC:
    - `aud_dacdat` = 0.
    - On the first boundary after reset, the channel is taken from LRCK (left boundary also captures and ticks).
    - Go to DELAY if I2S_MODE=1, else SHIFT with the MSB driven on this fall.
  - DELAY: `aud_dacdat` = 0 for this slot; next `bclk_fall` goes to SHIFT and drives the MSB.
  - SHIFT:
    - Drive the next bit of the channel's held sample, MSB to LSB.
    - Bit counter counts 0..BITS-1.
    - After the LSB is driven, the next `bclk_fall` goes to PAD.
  - PAD: `aud_dacdat` = 0 for the remaining slots of the channel.
- Boundary in any state: restart the channel sequence (DELAY or SHIFT-with-MSB) for the new channel.
- Boundary in DELAY, or in SHIFT before the LSB has been driven: additionally pulse `frame_err` for 1 `clk`; the partial word is abandoned.
- A boundary coinciding with the LSB slot is legal (exact-fit frames in left-justified mode with BITS slots per channel).
- Simultaneous capture and error: `sample_tick` and `frame_err` may pulse in the same cycle.
- Reset mid-frame:
  - `aud_dacdat` drops to 0 asynchronously.
  - After release, the block stays in WAIT_SYNC with output 0 until the next LRCK boundary; no partial word is ever emitted.
- No arithmetic on the samples: bits are passed exactly. Width of `left_in`/`right_in` equals BITS.

Test Plan:
1. Reset: `rst_n`=0 with BCLK running -> `aud_dacdat`=0, `sample_tick`=0, `frame_err`=0 throughout; after release, `aud_dacdat` stays 0 until the first LRCK edge.
2. I2S_MODE=1, 32 BCLK per channel, `left_in`=16'sh8001, `right_in`=16'sh7FFE -> sampled on BCLK rise:
   - left slot: 0, 1000000000000001, then fifteen 0s;
   - right slot: 0, 0111111111111110, then fifteen 0s;
   - one `sample_tick` per frame.
3. I2S_MODE=0, same stimulus -> left slot starts with 1000000000000001 in the first slot, followed by sixteen 0s; `frame_err` never asserts.
4. During the left slot, change `right_in` from 16'sh7FFE to 16'sh1234 -> the right slot still emits 0111111111111110; 16'sh1234 appears in the next frame's right slot.
5. I2S_MODE=1, 8 BCLK per channel -> `frame_err` pulses once per channel boundary; each slot emits 0 then the top 7 bits of the sample; `sample_tick` still pulses once per frame.
6. Assert `rst_n`=0 at left bit 5, release 3 BCLK later -> `aud_dacdat`=0 immediately and remains 0 through the right slot's end; normal framing resumes at the next LRCK edge with no `frame_err`.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC serialiser, slave to the codec's BCLK and DACLRCK.
// Codec clocks are oversampled in the clk domain; data changes one clk after each detected BCLK fall.
module i2s_dac_tx #(
  parameter int BITS     = 16,
  parameter bit I2S_MODE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [BITS-1:0] left_in,
  input  logic signed [BITS-1:0] right_in,
  input  logic                   aud_bclk,
  input  logic                   aud_daclrck,
  output logic                   aud_dacdat,
  output logic                   sample_tick,
  output logic                   frame_err
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {WAIT_SYNC, DELAY, SHIFT, PAD} state_t;

  state_t          state;
  logic [2:0]      bclk_sync;
  logic [1:0]      lrck_sync;
  logic            lrck_prev;
  logic            chan;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] hold_l, hold_r, shreg;

  logic            lrck, bclk_fall, boundary;
  logic [BITS-1:0] first_word, chan_word;

  assign lrck      = lrck_sync[1];
  assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
  assign boundary  = bclk_fall & (lrck != lrck_prev);
  // A left boundary captures this cycle, so its first word comes straight from left_in.
  assign first_word = lrck ? hold_r : left_in;
  assign chan_word  = chan ? hold_r : hold_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_daclrck};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SYNC;
      lrck_prev   <= 1'b0;
      chan        <= 1'b0;
      cnt         <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      shreg       <= '0;
      aud_dacdat  <= 1'b0;
      sample_tick <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      frame_err   <= 1'b0;
      if (bclk_fall) begin
        lrck_prev <= lrck;
        if (boundary) begin
          chan      <= lrck;
          cnt       <= '0;
          // Slot ended before the LSB went out: the partial word is dropped.
          frame_err <= (state == DELAY) || ((state == SHIFT) && (cnt != LAST));
          if (!lrck) begin
            hold_l      <= left_in;
            hold_r      <= right_in;
            sample_tick <= 1'b1;
          end
          if (I2S_MODE) begin
            state      <= DELAY;
            aud_dacdat <= 1'b0;
          end else begin
            state      <= SHIFT;
            aud_dacdat <= first_word[BITS-1];
            shreg      <= {first_word[BITS-2:0], 1'b0};
          end
        end else begin
          case (state)
            DELAY: begin
              state      <= SHIFT;
              cnt        <= '0;
              aud_dacdat <= chan_word[BITS-1];
              shreg      <= {chan_word[BITS-2:0], 1'b0};
            end
            SHIFT: begin
              if (cnt == LAST) begin
                state      <= PAD;
                aud_dacdat <= 1'b0;
              end else begin
                cnt        <= cnt + 1'b1;
                aud_dacdat <= shreg[BITS-1];
                shreg      <= {shreg[BITS-2:0], 1'b0};
              end
            end
            default: aud_dacdat <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench acting as codec master: drives BCLK/LRCK, samples DAC data on BCLK rise.
// Two instances (I2S and left-justified) share the stimulus and are checked against a slot-level model.
module tb_i2s_dac_tx;
  localparam int BITS = 16;
  localparam int H    = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic aud_bclk = 1'b1;
  logic aud_daclrck = 1'b0;
  logic signed [BITS-1:0] left_in = '0;
  logic signed [BITS-1:0] right_in = '0;
  logic [1:0] dat, tick, ferr;

  i2s_dac_tx #(.BITS(BITS), .I2S_MODE(1'b1)) u_i2s (
    .clk(clk), .rst_n(rst_n), .left_in(left_in), .right_in(right_in),
    .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(dat[0]), .sample_tick(tick[0]), .frame_err(ferr[0])
  );

  i2s_dac_tx #(.BITS(BITS), .I2S_MODE(1'b0)) u_lj (
    .clk(clk), .rst_n(rst_n), .left_in(left_in), .right_in(right_in),
    .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(dat[1]), .sample_tick(tick[1]), .frame_err(ferr[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_cnt [2] = '{0, 0};
  int err_cnt  [2] = '{0, 0};
  int tick_seen[2] = '{0, 0};
  int err_seen [2] = '{0, 0};
  logic [31:0] cap[2] = '{32'h0, 32'h0};

  // Slot-level codec view of each instance
  logic            m_lrp = 1'b0;
  logic            m_sync[2] = '{1'b0, 1'b0};
  logic            m_ch[2]   = '{1'b0, 1'b0};
  int              m_k[2]    = '{0, 0};
  logic [BITS-1:0] m_hl[2]   = '{16'h0, 16'h0};
  logic [BITS-1:0] m_hr[2]   = '{16'h0, 16'h0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tick[i]) tick_cnt[i]++;
      if (ferr[i]) err_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  // One BCLK period: LRCK changes with the fall, data checked just after the rise.
  // act: 0 none, 1 assert reset, 2 release reset (both mid high phase).
  task automatic slot(input logic lr, input int act);
    logic [1:0] eb, et, ee;
    logic [BITS-1:0] w;
    logic bnd;
    int d;
    eb = '0; et = '0; ee = '0;
    aud_daclrck = lr;
    aud_bclk = 1'b0;
    bnd = (lr != m_lrp);
    if (rst_n) begin
      m_lrp = lr;
      for (int i = 0; i < 2; i++) begin
        d = (i == 0) ? 1 : 0;
        if (bnd) begin
          ee[i] = m_sync[i] && (m_k[i] + 1 < d + BITS);
          if (!lr) begin
            m_hl[i] = left_in;
            m_hr[i] = right_in;
            et[i] = 1'b1;
          end
          m_sync[i] = 1'b1;
          m_k[i] = 0;
          m_ch[i] = lr;
        end else begin
          m_k[i]++;
        end
        w = m_ch[i] ? m_hr[i] : m_hl[i];
        if (m_sync[i] && m_k[i] >= d && m_k[i] < d + BITS)
          eb[i] = w[BITS-1-(m_k[i]-d)];
      end
    end
    #H;
    aud_bclk = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("dacdat", i, {31'b0, dat[i]}, {31'b0, eb[i]});
      chk("tick_per_slot", i, tick_cnt[i] - tick_seen[i], {31'b0, et[i]});
      chk("err_per_slot", i, err_cnt[i] - err_seen[i], {31'b0, ee[i]});
      tick_seen[i] = tick_cnt[i];
      err_seen[i] = err_cnt[i];
      cap[i] = {cap[i][30:0], dat[i]};
    end
    if (act == 1) begin
      #(H/2 - 1);
      rst_n = 1'b0;
      m_lrp = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_sync[i] = 1'b0;
        m_hl[i] = '0;
        m_hr[i] = '0;
      end
      #1;
      for (int i = 0; i < 2; i++) chk("async_reset_dacdat", i, {31'b0, dat[i]}, 32'h0);
      #(H/2 - 1);
    end else begin
      #(H/2 - 1);
      if (act == 2) rst_n = 1'b1;
      #(H/2);
    end
  endtask

  task automatic run_slots(input logic lr, input int n);
    for (int k = 0; k < n; k++) slot(lr, 0);
  endtask

  int t0[2], e0[2];

  initial begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_dacdat", i, {31'b0, dat[i]}, 32'h0);
      chk("reset_tick", i, {31'b0, tick[i]}, 32'h0);
      chk("reset_err", i, {31'b0, ferr[i]}, 32'h0);
    end
    #2;

    // Reset with BCLK running, released in the left slot; no data until framing seen
    left_in = 16'h8001;
    right_in = 16'h7FFE;
    for (int k = 0; k < 32; k++) slot(1'b0, (k == 3) ? 2 : 0);
    run_slots(1'b1, 32);
    for (int i = 0; i < 2; i++) chk("post_reset_right_word", i, cap[i], 32'h0);

    // 32 BCLK per channel, three frames
    for (int i = 0; i < 2; i++) begin t0[i] = tick_cnt[i]; e0[i] = err_cnt[i]; end
    for (int f = 0; f < 3; f++) begin
      run_slots(1'b0, 32);
      for (int i = 0; i < 2; i++) chk("left_word32", i, cap[i], (i == 0) ? 32'h4000_8000 : 32'h8001_0000);
      run_slots(1'b1, 32);
      for (int i = 0; i < 2; i++) chk("right_word32", i, cap[i], (i == 0) ? 32'h3FFF_0000 : 32'h7FFE_0000);
    end
    for (int i = 0; i < 2; i++) begin
      chk("ticks_3frames", i, tick_cnt[i] - t0[i], 32'd3);
      chk("errs_3frames", i, err_cnt[i] - e0[i], 32'd0);
    end

    // right_in changes mid left slot: held value used until next frame
    run_slots(1'b0, 16);
    right_in = 16'h1234;
    run_slots(1'b0, 16);
    run_slots(1'b1, 32);
    for (int i = 0; i < 2; i++) chk("right_held", i, cap[i], (i == 0) ? 32'h3FFF_0000 : 32'h7FFE_0000);
    run_slots(1'b0, 32);
    run_slots(1'b1, 32);
    for (int i = 0; i < 2; i++) chk("right_new", i, cap[i], (i == 0) ? 32'h091A_0000 : 32'h1234_0000);

    // Short frames: 8 BCLK per channel
    right_in = 16'h7FFE;
    for (int i = 0; i < 2; i++) begin t0[i] = tick_cnt[i]; e0[i] = err_cnt[i]; end
    for (int f = 0; f < 3; f++) begin
      run_slots(1'b0, 8);
      for (int i = 0; i < 2; i++) chk("left_word8", i, {24'h0, cap[i][7:0]}, (i == 0) ? 32'h40 : 32'h80);
      run_slots(1'b1, 8);
      for (int i = 0; i < 2; i++) chk("right_word8", i, {24'h0, cap[i][7:0]}, (i == 0) ? 32'h3F : 32'h7F);
    end
    for (int i = 0; i < 2; i++) begin
      chk("ticks_short", i, tick_cnt[i] - t0[i], 32'd3);
      chk("errs_short", i, err_cnt[i] - e0[i], 32'd5);
    end

    // Exact fit: 16 BCLK per channel, legal for left-justified only
    for (int i = 0; i < 2; i++) e0[i] = err_cnt[i];
    for (int f = 0; f < 2; f++) begin
      run_slots(1'b0, 16);
      for (int i = 0; i < 2; i++) chk("left_word16", i, {16'h0, cap[i][15:0]}, (i == 0) ? 32'h4000 : 32'h8001);
      run_slots(1'b1, 16);
      for (int i = 0; i < 2; i++) chk("right_word16", i, {16'h0, cap[i][15:0]}, (i == 0) ? 32'h3FFF : 32'h7FFE);
    end
    for (int i = 0; i < 2; i++) chk("errs_exact_fit", i, err_cnt[i] - e0[i], (i == 0) ? 32'd4 : 32'd1);

    // Reset in the middle of the left word, released three BCLK later
    left_in = 16'hFFFF;
    for (int k = 0; k < 32; k++) slot(1'b0, (k == 6) ? 1 : ((k == 9) ? 2 : 0));
    for (int i = 0; i < 2; i++) begin t0[i] = tick_cnt[i]; e0[i] = err_cnt[i]; end
    run_slots(1'b1, 32);
    for (int i = 0; i < 2; i++) chk("reset_frame_right", i, cap[i], 32'h0);
    left_in = 16'h8001;
    run_slots(1'b0, 32);
    for (int i = 0; i < 2; i++) chk("resume_left", i, cap[i], (i == 0) ? 32'h4000_8000 : 32'h8001_0000);
    run_slots(1'b1, 32);
    for (int i = 0; i < 2; i++) begin
      chk("resume_right", i, cap[i], (i == 0) ? 32'h3FFF_0000 : 32'h7FFE_0000);
      chk("resume_ticks", i, tick_cnt[i] - t0[i], 32'd1);
      chk("resume_errs", i, err_cnt[i] - e0[i], 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
